memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter size, default 32, datapath width.
REQ-002 SHALL have ports: clk in 1, pipeline clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have ex_valid_i in 1, EX/MEM register holds a live instruction.
REQ-004 SHALL have calculated_result_i in size, ALU result or memory address.
REQ-005 SHALL have store_data_i in size, store data.
REQ-006 SHALL have control_signal_i in 12, with fields [11:7] rd, [6] wb_en, [5] unused, [4] mem_read, [3] mem_write, [2:0] funct3.
REQ-007 SHALL have the data-memory ports dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out size, dmem_be_o out 4, dmem_wdata_o out size, dmem_gnt_i in 1, dmem_rvalid_i in 1 and dmem_rdata_i in size.
REQ-008 SHALL have stall_o out 1; upstream holds all EX/MEM inputs stable while it is high.
REQ-009 SHALL have data_from_mem_o out size, the combinational forward of calculated_result_i.
REQ-010 SHALL have wb_valid_o, wb_we_o, wb_rd_o (5) and wb_data_o (size), all registered MEM/WB outputs.
REQ-011 SHALL have misalign_o out 1, a registered one-cycle error pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, REQ and WAIT.
REQ-013 IDLE: SHALL drive dmem_req_o combinationally when ex_valid_i and (mem_read or mem_write) are both true.
REQ-014 IDLE: if the request is not granted, SHALL go to REQ. A granted load SHALL go to WAIT. A granted store SHALL complete and stay in IDLE.
REQ-015 REQ: SHALL hold dmem_req_o and all request fields stable until dmem_gnt_i; the transitions SHALL match REQ-014.
REQ-016 WAIT: dmem_req_o SHALL be 0. On dmem_rvalid_i, the load SHALL complete and the FSM SHALL return to IDLE.
REQ-017 SHALL drive stall_o = live memory operation AND NOT (completing this cycle).
REQ-018 A non-memory op SHALL never stall and SHALL update wb_* on the next edge with wb_data_o = calculated_result_i.
REQ-019 SHALL derive byte enables from funct3[1:0] (00 byte, 01 half, 10 word), giving 0001, 0011 or 1111 shifted left by addr[1:0].
REQ-020 SHALL drive dmem_addr_o as the word-aligned address ({addr[size-1:2],2'b00}).
REQ-021 SHALL drive dmem_wdata_o with store_data_i replicated per size (byte x4, half x2).
REQ-022 SHALL latch addr[1:0] and funct3 at grant.
REQ-023 On load completion, SHALL shift the load data right by offset*8 and extend it: sign extension if funct3[2]=0, zero extension if funct3[2]=1.
REQ-024 wb_we_o SHALL equal wb_en AND retiring, and SHALL be 0 for stores.
REQ-025 wb_valid_o SHALL be 1 for exactly one cycle per retired instruction.
REQ-026 wb_valid_o SHALL be 0 while stalled.
REQ-027 dmem_rvalid_i SHALL be ignored in IDLE and REQ.
REQ-028 dmem_gnt_i SHALL be ignored when dmem_req_o is 0.
REQ-029 A new operation SHALL be able to issue in IDLE in the cycle after a completion, with no bubble required.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE, and all wb_* outputs and misalign_o SHALL be 0.
REQ-031 Reset during REQ or WAIT SHALL abandon the transaction: dmem_req_o is 0 in the cycle after reset, and a late dmem_rvalid_i SHALL be dropped.

Configuration
REQ-032 With MEM_MISALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, SHALL issue no request, SHALL retire next edge with wb_we_o=0 and misalign_o=1 for one cycle, and SHALL not stall.
REQ-033 Without MEM_MISALIGN_CHECK_EN: misalign_o SHALL be tied 0 and the access SHALL issue with the shifted byte enables truncated to 4 bits.

Structure
REQ-034 The shared package SHALL hold the FSM state enum, the control_signal field-index constants and the funct3 size/sign encodings.
REQ-035 Byte-enable, write replication and load extraction/extension SHALL live in one combinational sub-module named lsu_data_align.

Verification
REQ-036 ALU op: calculated_result_i=0x1234, rd=5, wb_en=1 -> no stall; next edge wb_data_o=0x1234, wb_rd_o=5, wb_we_o=1.
REQ-037 LB at addr 0x103, gnt same cycle, rvalid+1 with rdata=0x80000000 -> be=1000; wb_data_o=0xFFFFFF80; stall_o high for 1 cycle.
REQ-038 SH at addr 0x202, data 0xABCD, gnt delayed 3 cycles -> req held 4 cycles; be=1100, wdata=0xABCDABCD; stall_o high 3 cycles; wb_we_o=0.
REQ-039 LHU at 0x6 with rdata=0xF00D0000 -> wb_data_o=0x0000F00D.
REQ-040 Reset asserted in WAIT, then rvalid 2 cycles later -> no wb_valid_o; FSM in IDLE.
REQ-041 With MEM_MISALIGN_CHECK_EN: LW at 0x102 -> dmem_req_o never 1; misalign_o=1 for one cycle; wb_we_o=0.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types and encodings for the memory access stage: FSM states,
// control_signal field positions and funct3 access-size/sign encodings.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mas_state_e;

  localparam int CTRL_RD_HI     = 11;
  localparam int CTRL_RD_LO     = 7;
  localparam int CTRL_WB_EN     = 6;
  localparam int CTRL_UNUSED    = 5;
  localparam int CTRL_MEM_READ  = 4;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_F3_HI     = 2;
  localparam int CTRL_F3_LO     = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // funct3[2] set selects zero extension on loads
  localparam int F3_UNSIGNED = 2;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and write replication for the
// outgoing request, plus right-shift and sign/zero extension of load data.
module lsu_data_align
  import memory_access_stage_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [2:0]      req_funct3_i,
  input  logic [1:0]      req_off_i,
  input  logic [size-1:0] store_data_i,
  output logic [3:0]      be_o,
  output logic [size-1:0] wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [size-1:0] load_data_i,
  output logic [size-1:0] load_result_o
);

  logic [3:0]      be_base;
  logic [size-1:0] shifted;
  logic            sign;

  always_comb begin
    be_base = 4'b1111;
    wdata_o = store_data_i;
    case (req_funct3_i[1:0])
      SZ_BYTE: begin
        be_base = 4'b0001;
        wdata_o = {(size/8){store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_base = 4'b0011;
        wdata_o = {(size/16){store_data_i[15:0]}};
      end
      default: ;
    endcase
    // Lanes shifted past bit 3 fall off: a misaligned access keeps only its low lanes
    be_o = be_base << req_off_i;
  end

  always_comb begin
    shifted = load_data_i >> {ld_off_i, 3'b000};
    sign    = 1'b0;
    case (ld_funct3_i[1:0])
      SZ_BYTE: begin
        sign          = ~ld_funct3_i[F3_UNSIGNED] & shifted[7];
        load_result_o = {{(size-8){sign}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sign          = ~ld_funct3_i[F3_UNSIGNED] & shifted[15];
        load_result_o = {{(size-16){sign}}, shifted[15:0]};
      end
      default: load_result_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues data-memory requests (IDLE/REQ/WAIT), stalls
// upstream until the access retires, and registers the MEM/WB outputs.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_i,
  input  logic [size-1:0] calculated_result_i,
  input  logic [size-1:0] store_data_i,
  input  logic [11:0]     control_signal_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [size-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [size-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [size-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [size-1:0] data_from_mem_o,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [size-1:0] wb_data_o,
  output logic            misalign_o
);

  mas_state_e state_q, state_d;

  logic [4:0] rd;
  logic       wb_en, mem_read, mem_write;
  logic [2:0] funct3;
  logic [1:0] off;
  logic       ctrl_unused;
  logic       mem_op, misaligned, issue;

  logic       req, busy, retire, retire_load;
  logic       grant;

  logic [4:0] lat_rd_q;
  logic       lat_wb_en_q;
  logic [2:0] lat_f3_q;
  logic [1:0] lat_off_q;

  logic [size-1:0] load_result;

  logic            wb_valid_d, wb_we_d;
  logic [4:0]      wb_rd_d;
  logic [size-1:0] wb_data_d;
  logic            wb_valid_q, wb_we_q;
  logic [4:0]      wb_rd_q;
  logic [size-1:0] wb_data_q;

  assign rd          = control_signal_i[CTRL_RD_HI:CTRL_RD_LO];
  assign wb_en       = control_signal_i[CTRL_WB_EN];
  assign ctrl_unused = control_signal_i[CTRL_UNUSED];
  assign mem_read    = control_signal_i[CTRL_MEM_READ];
  assign mem_write   = control_signal_i[CTRL_MEM_WRITE];
  assign funct3      = control_signal_i[CTRL_F3_HI:CTRL_F3_LO];
  assign off         = calculated_result_i[1:0];

  assign mem_op = ex_valid_i & (mem_read | mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (funct3[1:0])
        SZ_HALF: misaligned = off[0];
        SZ_WORD: misaligned = |off;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Only an IDLE-state decode can trap; REQ/WAIT hold an already-issued access
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= (state_q == ST_IDLE) & misaligned;
  end

  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign issue = mem_op & ~misaligned;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (!dmem_gnt_i)    state_d = ST_REQ;
          else if (!mem_write) state_d = ST_WAIT;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) state_d = mem_write ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req         = 1'b0;
    busy        = 1'b0;
    retire      = 1'b0;
    retire_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req    = issue;
        busy   = issue;
        retire = ex_valid_i & (~mem_op | misaligned | (issue & dmem_gnt_i & mem_write));
      end
      ST_REQ: begin
        req    = 1'b1;
        busy   = 1'b1;
        retire = dmem_gnt_i & mem_write;
      end
      ST_WAIT: begin
        busy        = 1'b1;
        retire      = dmem_rvalid_i;
        retire_load = dmem_rvalid_i;
      end
      default: ;
    endcase
  end

  assign grant           = req & dmem_gnt_i;
  assign stall_o         = busy & ~retire;
  assign dmem_req_o      = req;
  assign dmem_we_o       = mem_write;
  assign dmem_addr_o     = {calculated_result_i[size-1:2], 2'b00};
  assign data_from_mem_o = calculated_result_i;

  // Load context captured at grant so WAIT does not depend on upstream inputs
  always_ff @(posedge clk) begin
    if (grant) begin
      lat_rd_q    <= rd;
      lat_wb_en_q <= wb_en;
      lat_f3_q    <= funct3;
      lat_off_q   <= off;
    end
  end

  lsu_data_align #(.size(size)) u_align (
    .req_funct3_i  (funct3),
    .req_off_i     (off),
    .store_data_i  (store_data_i),
    .be_o          (dmem_be_o),
    .wdata_o       (dmem_wdata_o),
    .ld_funct3_i   (lat_f3_q),
    .ld_off_i      (lat_off_q),
    .load_data_i   (dmem_rdata_i),
    .load_result_o (load_result)
  );

  always_comb begin
    wb_valid_d = retire;
    wb_rd_d    = retire_load ? lat_rd_q : rd;
    wb_we_d    = retire & (retire_load ? lat_wb_en_q : (wb_en & ~mem_op));
    wb_data_d  = retire_load ? load_result : calculated_result_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_we_o    = wb_we_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: expected MEM/WB retirements are queued
// as stimulus is driven and checked when wb_valid_o fires.
module tb_memory_access_stage;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid_i;
  logic [SIZE-1:0] calculated_result_i;
  logic [SIZE-1:0] store_data_i;
  logic [11:0]     control_signal_i;
  logic            dmem_req_o, dmem_we_o;
  logic [SIZE-1:0] dmem_addr_o;
  logic [3:0]      dmem_be_o;
  logic [SIZE-1:0] dmem_wdata_o;
  logic            dmem_gnt_i, dmem_rvalid_i;
  logic [SIZE-1:0] dmem_rdata_i;
  logic            stall_o;
  logic [SIZE-1:0] data_from_mem_o;
  logic            wb_valid_o, wb_we_o;
  logic [4:0]      wb_rd_o;
  logic [SIZE-1:0] wb_data_o;
  logic            misalign_o;

  always #5 clk = ~clk;

  memory_access_stage #(.size(SIZE)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_valid_i          (ex_valid_i),
    .calculated_result_i (calculated_result_i),
    .store_data_i        (store_data_i),
    .control_signal_i    (control_signal_i),
    .dmem_req_o          (dmem_req_o),
    .dmem_we_o           (dmem_we_o),
    .dmem_addr_o         (dmem_addr_o),
    .dmem_be_o           (dmem_be_o),
    .dmem_wdata_o        (dmem_wdata_o),
    .dmem_gnt_i          (dmem_gnt_i),
    .dmem_rvalid_i       (dmem_rvalid_i),
    .dmem_rdata_i        (dmem_rdata_i),
    .stall_o             (stall_o),
    .data_from_mem_o     (data_from_mem_o),
    .wb_valid_o          (wb_valid_o),
    .wb_we_o             (wb_we_o),
    .wb_rd_o             (wb_rd_o),
    .wb_data_o           (wb_data_o),
    .misalign_o          (misalign_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wb    = 0;
  int   n_push  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] mk_ctrl(input logic [4:0] rd, input logic wb_en,
                                          input logic mr, input logic mw, input logic [2:0] f3);
    return {rd, wb_en, 1'b0, mr, mw, f3};
  endfunction

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic we, input logic cd);
    exp_t e;
    e.data = d; e.rd = rd; e.we = we; e.chk_data = cd;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid_i       = 1'b0;
    control_signal_i = '0;
    dmem_gnt_i       = 1'b0;
    dmem_rvalid_i    = 1'b0;
  endtask

  // Load with gnt after gdly waiting cycles and rvalid rdly cycles after grant
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdat, input int gdly, input int rdly,
                         input logic [31:0] expd);
    ex_valid_i          = 1'b1;
    calculated_result_i = addr;
    control_signal_i    = mk_ctrl(rd, 1'b1, 1'b1, 1'b0, f3);
    dmem_rdata_i        = rdat;
    dmem_rvalid_i       = 1'b0;
    push(expd, rd, 1'b1, 1'b1);
    for (int i = 0; i <= gdly; i++) begin
      dmem_gnt_i = (i == gdly);
      #1;
      chk("ld_req", {31'b0, dmem_req_o}, 32'd1);
      chk("ld_req_stall", {31'b0, stall_o}, 32'd1);
      tick();
    end
    dmem_gnt_i = 1'b0;
    for (int i = 0; i <= rdly; i++) begin
      dmem_rvalid_i = (i == rdly);
      #1;
      chk("ld_wait_req", {31'b0, dmem_req_o}, 32'd0);
      chk("ld_wait_stall", {31'b0, stall_o}, (i == rdly) ? 32'd0 : 32'd1);
      tick();
    end
    idle_in();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wb_valid_o === 1'b1) begin
      n_wb++;
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, e.rd});
        chk("wb_we", {31'b0, wb_we_o}, {31'b0, e.we});
        if (e.chk_data) chk("wb_data", wb_data_o, e.data);
      end
    end
`ifndef MEM_MISALIGN_CHECK_EN
    chk("misalign_tied0", {31'b0, misalign_o}, 32'd0);
`endif
  end

  initial begin
    int req_cyc;
    int stall_cyc;
    reset = 1'b1;
    idle_in();
    calculated_result_i = '0;
    store_data_i        = '0;
    dmem_rdata_i        = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("rst_wb_we", {31'b0, wb_we_o}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);

    // ALU op
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h1234;
    control_signal_i    = mk_ctrl(5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    chk("alu_stall", {31'b0, stall_o}, 32'd0);
    chk("alu_req", {31'b0, dmem_req_o}, 32'd0);
    chk("alu_fwd", data_from_mem_o, 32'h1234);
    push(32'h1234, 5'd5, 1'b1, 1'b1);
    tick();
    idle_in();

    // LB 0x103, granted immediately, rvalid next cycle
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h103;
    control_signal_i    = mk_ctrl(5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    dmem_gnt_i          = 1'b1;
    #1;
    chk("lb_req", {31'b0, dmem_req_o}, 32'd1);
    chk("lb_we", {31'b0, dmem_we_o}, 32'd0);
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_be", {28'b0, dmem_be_o}, 32'h8);
    chk("lb_stall", {31'b0, stall_o}, 32'd1);
    push(32'hFFFFFF80, 5'd7, 1'b1, 1'b1);
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80000000;
    #1;
    chk("lb_wait_req", {31'b0, dmem_req_o}, 32'd0);
    chk("lb_wait_stall", {31'b0, stall_o}, 32'd0);
    tick();
    idle_in();

    // SH 0x202, gnt after 3 cycles, stray rvalid while in REQ
    req_cyc   = 0;
    stall_cyc = 0;
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h202;
    store_data_i        = 32'hABCD;
    control_signal_i    = mk_ctrl(5'd3, 1'b1, 1'b0, 1'b1, 3'b001);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt_i    = (i == 3);
      dmem_rvalid_i = (i == 1);
      #1;
      if (dmem_req_o) req_cyc++;
      if (stall_o) stall_cyc++;
      if (i == 0) begin
        chk("sh_be", {28'b0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
        chk("sh_we", {31'b0, dmem_we_o}, 32'd1);
        chk("sh_addr", dmem_addr_o, 32'h200);
      end
      if (i == 3) push(32'h0, 5'd3, 1'b0, 1'b0);
      tick();
    end
    chk("sh_req_cycles", req_cyc, 32'd4);
    chk("sh_stall_cycles", stall_cyc, 32'd3);

    // LHU back-to-back with the store completion, then more loads
    do_load(32'h6, 3'b101, 5'd9, 32'hF00D0000, 0, 0, 32'h0000F00D);
    do_load(32'h101, 3'b100, 5'd10, 32'h0000A500, 0, 0, 32'h000000A5);
    do_load(32'h10, 3'b010, 5'd1, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF);
    do_load(32'h102, 3'b000, 5'd2, 32'h00800000, 0, 0, 32'hFFFFFF80);

    // Reset while in WAIT, late rvalid must be dropped
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h20;
    control_signal_i    = mk_ctrl(5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    dmem_gnt_i          = 1'b1;
    #1;
    chk("rw_req", {31'b0, dmem_req_o}, 32'd1);
    tick();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_req_after", {31'b0, dmem_req_o}, 32'd0);
    chk("rw_stall_after", {31'b0, stall_o}, 32'd0);
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h55555555;
    #1;
    chk("rw_late_stall", {31'b0, stall_o}, 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rw_no_wb", {31'b0, wb_valid_o}, 32'd0);

    // Grant with no request is ignored
    dmem_gnt_i = 1'b1;
    #1;
    chk("gnt_noreq", {31'b0, dmem_req_o}, 32'd0);
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    chk("gnt_noreq_wb", {31'b0, wb_valid_o}, 32'd0);

    // FSM back in IDLE: ALU op retires, load issues at once
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h77;
    control_signal_i    = mk_ctrl(5'd6, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    chk("post_rst_stall", {31'b0, stall_o}, 32'd0);
    push(32'h77, 5'd6, 1'b1, 1'b1);
    tick();
    do_load(32'h30, 3'b010, 5'd11, 32'h0BADF00D, 0, 0, 32'h0BADF00D);

    // Misaligned word load
    ex_valid_i          = 1'b1;
    calculated_result_i = 32'h102;
    control_signal_i    = mk_ctrl(5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
`ifdef MEM_MISALIGN_CHECK_EN
    dmem_gnt_i = 1'b0;
    #1;
    chk("mis_req", {31'b0, dmem_req_o}, 32'd0);
    chk("mis_stall", {31'b0, stall_o}, 32'd0);
    push(32'h0, 5'd8, 1'b0, 1'b0);
    tick();
    idle_in();
    #1;
    chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
    chk("mis_we", {31'b0, wb_we_o}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
`else
    dmem_gnt_i = 1'b1;
    #1;
    chk("mis_req", {31'b0, dmem_req_o}, 32'd1);
    chk("mis_be", {28'b0, dmem_be_o}, 32'hC);
    push(32'h00001234, 5'd8, 1'b1, 1'b1);
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h12345678;
    tick();
    idle_in();
    #1;
    chk("mis_flag", {31'b0, misalign_o}, 32'd0);
`endif

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("wb_pulse_count", n_wb, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
